// File: rtl/fpga_test_step_prod_acc.sv
// fpga_test_step_prod_acc: sums ACC_LEN products, rounds/shifts/saturates, registered valid/ready output.
// Optional sat_flag output enabled by FPGA_TEST_STEP_PROD_ACC_SAT_FLAG_EN.
module fpga_test_step_prod_acc #(
  parameter int DIN_WIDTH = 30,
  parameter int ACC_LEN   = 16,
  parameter int ACC_WIDTH = 34,
  parameter int SHIFT     = 14,
  parameter int OUT_WIDTH = 16
) (
  input  logic                 ap_clk,
  input  logic                 ap_rst_n,
  input  logic [DIN_WIDTH-1:0] prod_din,
  input  logic                 prod_vld,
  output logic                 prod_rdy,
  output logic [OUT_WIDTH-1:0] dout,
  output logic                 dout_vld,
  input  logic                 dout_rdy
`ifdef FPGA_TEST_STEP_PROD_ACC_SAT_FLAG_EN
  ,
  output logic                 sat_flag
`endif
);
  localparam int CW = $clog2(ACC_LEN + 1);
  localparam logic [ACC_WIDTH:0] RND = {{ACC_WIDTH{1'b0}}, 1'b1} << (SHIFT - 1);
  localparam logic [ACC_WIDTH:0] MAX = {{(ACC_WIDTH + 1 - OUT_WIDTH){1'b0}}, {OUT_WIDTH{1'b1}}};
  if (ACC_WIDTH < DIN_WIDTH + $clog2(ACC_LEN) || ACC_LEN < 2 || SHIFT < 1 || OUT_WIDTH > ACC_WIDTH) begin : g_bad_params
    $error("fpga_test_step_prod_acc: illegal parameter combination");
  end
  typedef enum logic [1:0] {IDLE, ACC, OUT} state_t;
  state_t               state_q, state_d;
  logic [ACC_WIDTH-1:0] acc_q, acc_d, din_ext, sum;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [OUT_WIDTH-1:0] dout_q, dout_d;
  logic                 vld_q, vld_d, rdy_q, rdy_d, accept, last, sat, sat_q, sat_d;
  logic [ACC_WIDTH:0]   full, q;
  always_comb begin
    accept  = prod_vld & rdy_q;
    din_ext = {{(ACC_WIDTH - DIN_WIDTH){1'b0}}, prod_din};
    sum     = acc_q + din_ext;
    last    = (state_q == ACC) && accept && (cnt_q == CW'(ACC_LEN - 1));
    // Rounding add is one bit wider than the accumulator so it can never wrap.
    full    = {1'b0, sum} + RND;
    q       = full >> SHIFT;
    sat     = q > MAX;
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    dout_d  = dout_q;
    vld_d   = vld_q;
    sat_d   = sat_q;
    case (state_q)
      IDLE: if (accept) begin
        acc_d   = din_ext;
        cnt_d   = CW'(1);
        state_d = ACC;
      end
      ACC: if (accept) begin
        acc_d = sum;
        cnt_d = cnt_q + CW'(1);
        if (last) begin
          state_d = OUT;
          dout_d  = sat ? '1 : q[OUT_WIDTH-1:0];
          vld_d   = 1'b1;
          sat_d   = sat;
        end
      end
      default: if (dout_rdy) begin
        acc_d   = '0;
        cnt_d   = '0;
        vld_d   = 1'b0;
        sat_d   = 1'b0;
        state_d = IDLE;
      end
    endcase
    rdy_d = state_d != OUT;
  end
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state_q <= IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      dout_q  <= '0;
      vld_q   <= 1'b0;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      dout_q  <= dout_d;
      vld_q   <= vld_d;
      rdy_q   <= rdy_d;
    end
  end
`ifdef FPGA_TEST_STEP_PROD_ACC_SAT_FLAG_EN
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) sat_q <= 1'b0;
    else sat_q <= sat_d;
  end
  assign sat_flag = sat_q;
`else
  assign sat_q = 1'b0;
`endif
  assign prod_rdy = rdy_q;
  assign dout     = dout_q;
  assign dout_vld = vld_q;
endmodule

// File: tb/tb_fpga_test_step_prod_acc.sv
// tb_fpga_test_step_prod_acc: directed frames with hand-computed results for the product accumulator.
module tb_fpga_test_step_prod_acc;
  logic        ap_clk = 1'b0;
  logic        ap_rst_n;
  logic [29:0] prod_din;
  logic        prod_vld;
  logic        prod_rdy;
  logic [15:0] dout;
  logic        dout_vld;
  logic        dout_rdy;
  int          total = 0;
  int          bad = 0;
  logic [15:0] held;
`ifdef FPGA_TEST_STEP_PROD_ACC_SAT_FLAG_EN
  logic        sat_flag;
`endif
  fpga_test_step_prod_acc dut (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .prod_din(prod_din), .prod_vld(prod_vld),
    .prod_rdy(prod_rdy), .dout(dout), .dout_vld(dout_vld), .dout_rdy(dout_rdy)
`ifdef FPGA_TEST_STEP_PROD_ACC_SAT_FLAG_EN
    , .sat_flag(sat_flag)
`endif
  );
  always #5 ap_clk = ~ap_clk;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask
  // Called at a negedge; returns at the negedge after the accepting edge with prod_vld dropped.
  task automatic push(input logic [29:0] d);
    int n = 0;
    prod_din = d;
    prod_vld = 1'b1;
    while (!prod_rdy && n < 50) begin
      @(negedge ap_clk);
      n++;
    end
    chk("push_rdy", 64'(prod_rdy), 64'd1);
    @(posedge ap_clk);
    @(negedge ap_clk);
    prod_vld = 1'b0;
  endtask
  task automatic frame(input logic [29:0] a, input logic [29:0] b);
    push(a);
    for (int i = 0; i < 15; i++) push(b);
  endtask
  initial begin
    ap_rst_n = 1'b0;
    prod_din = '0;
    prod_vld = 1'b0;
    dout_rdy = 1'b1;
    #12;
    chk("rst_prod_rdy", 64'(prod_rdy), 64'd0);
    chk("rst_dout_vld", 64'(dout_vld), 64'd0);
    chk("rst_dout", 64'(dout), 64'd0);
    @(negedge ap_clk);
    ap_rst_n = 1'b1;
    @(negedge ap_clk);
    chk("rel_prod_rdy", 64'(prod_rdy), 64'd1);
    push(30'd16384);
    for (int i = 0; i < 14; i++) push(30'd16384);
    chk("pre_last_vld", 64'(dout_vld), 64'd0);
    push(30'd16384);
    chk("def_vld", 64'(dout_vld), 64'd1);
    chk("def_dout", 64'(dout), 64'd16);
    chk("def_rdy_out", 64'(prod_rdy), 64'd0);
`ifdef FPGA_TEST_STEP_PROD_ACC_SAT_FLAG_EN
    chk("def_sat", 64'(sat_flag), 64'd0);
`endif
    @(negedge ap_clk);
    chk("def_vld_clr", 64'(dout_vld), 64'd0);
    chk("def_idle_rdy", 64'(prod_rdy), 64'd1);
    frame(30'd8192, 30'd0);
    chk("rnd_up", 64'(dout), 64'd1);
    @(negedge ap_clk);
    frame(30'd8191, 30'd0);
    chk("rnd_dn_vld", 64'(dout_vld), 64'd1);
    chk("rnd_dn", 64'(dout), 64'd0);
    @(negedge ap_clk);
    frame(30'h3FFF_FFFF, 30'h3FFF_FFFF);
    chk("sat_dout", 64'(dout), 64'd65535);
`ifdef FPGA_TEST_STEP_PROD_ACC_SAT_FLAG_EN
    chk("sat_flag", 64'(sat_flag), 64'd1);
    @(negedge ap_clk);
    chk("sat_flag_clr", 64'(sat_flag), 64'd0);
`else
    @(negedge ap_clk);
`endif
    dout_rdy = 1'b0;
    frame(30'd32768, 30'd32768);
    chk("bp_vld", 64'(dout_vld), 64'd1);
    chk("bp_dout", 64'(dout), 64'd32);
    held = dout;
    prod_din = 30'd16384;
    prod_vld = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge ap_clk);
      chk("bp_hold_vld", 64'(dout_vld), 64'd1);
      chk("bp_hold_dout", 64'(dout), 64'(held));
      chk("bp_hold_rdy", 64'(prod_rdy), 64'd0);
    end
    dout_rdy = 1'b1;
    @(negedge ap_clk);
    chk("bp_release_vld", 64'(dout_vld), 64'd0);
    chk("bp_release_rdy", 64'(prod_rdy), 64'd1);
    @(posedge ap_clk);
    @(negedge ap_clk);
    prod_vld = 1'b0;
    for (int i = 0; i < 14; i++) push(30'd16384);
    chk("bp_held_not_lost_vld", 64'(dout_vld), 64'd0);
    push(30'd16384);
    chk("bp_next_vld", 64'(dout_vld), 64'd1);
    chk("bp_next_dout", 64'(dout), 64'd16);
    dout_rdy = 1'b0;
    @(negedge ap_clk);
    dout_rdy = 1'b1;
    @(negedge ap_clk);
    for (int i = 0; i < 16; i++) begin
      repeat ($urandom_range(0, 3)) @(negedge ap_clk);
      if (i == 15) chk("gap_pre_vld", 64'(dout_vld), 64'd0);
      push(30'd16384);
    end
    chk("gap_vld", 64'(dout_vld), 64'd1);
    chk("gap_dout", 64'(dout), 64'd16);
    @(negedge ap_clk);
    for (int i = 0; i < 7; i++) push(30'd16384);
    #2 ap_rst_n = 1'b0;
    #1;
    chk("mid_rst_dout", 64'(dout), 64'd0);
    chk("mid_rst_vld", 64'(dout_vld), 64'd0);
    chk("mid_rst_rdy", 64'(prod_rdy), 64'd0);
    @(negedge ap_clk);
    ap_rst_n = 1'b1;
    @(negedge ap_clk);
    chk("mid_rel_rdy", 64'(prod_rdy), 64'd1);
    for (int i = 0; i < 15; i++) push(30'd16384);
    chk("mid_partial_dropped", 64'(dout_vld), 64'd0);
    push(30'd16384);
    chk("mid_vld", 64'(dout_vld), 64'd1);
    chk("mid_dout", 64'(dout), 64'd16);
    @(negedge ap_clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
